// File: rtl/motion_macc_feeder_pkg.sv
// -----------------------------------------------------------------------------
// motion_macc_feeder_pkg
// Shared definitions for the motion MACC sequencing wrapper: FSM state
// encoding (one-hot, same style as the HLS core), operand/result counts,
// datapath width and the default WAIT timeout.
// -----------------------------------------------------------------------------
package motion_macc_feeder_pkg;

  localparam int NUM_OPERANDS           = 10;
  localparam int NUM_RESULTS            = 3;
  localparam int WORD_W                 = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int WAIT_CNT_W             = 16;

  // One-hot encoding, one bit per state.
  typedef enum logic [3:0] {
    ST_LOAD  = 4'b0001,
    ST_START = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_DRAIN = 4'b1000
  } feeder_state_e;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/motion_result_serializer.sv
// -----------------------------------------------------------------------------
// motion_result_serializer
// Holds the three core results and plays them out on a valid/ready stream.
//
// Ports:
//   ap_clk, ap_rst       clock, synchronous active-high reset
//   capture_en           high while the controller waits on the core
//   res_vld[2:0]         per-result valid from the core (bit N-1 = outN)
//   res_in1..res_in3     result words from the core
//   drain_start          one-cycle pulse: begin playing out res[0..2]
//   m_data/m_valid/m_ready/m_last  output stream
//   last_hs              the out3 word is being accepted this cycle
// -----------------------------------------------------------------------------
module motion_result_serializer
  import motion_macc_feeder_pkg::*;
(
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              capture_en,
  input  logic [2:0]        res_vld,
  input  logic [WORD_W-1:0] res_in1,
  input  logic [WORD_W-1:0] res_in2,
  input  logic [WORD_W-1:0] res_in3,
  input  logic              drain_start,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              last_hs
);

  word_t       res_r      [NUM_RESULTS];
  word_t       res_next_s [NUM_RESULTS];
  word_t       res_in_s   [NUM_RESULTS];
  word_t       next_word_s;
  logic [1:0]  idx_r;
  logic [1:0]  idx_inc_s;
  logic        m_valid_r;
  logic        m_last_r;
  word_t       m_data_r;
  logic        out_hs_s;

  assign res_in_s[0] = res_in1;
  assign res_in_s[1] = res_in2;
  assign res_in_s[2] = res_in3;

  assign idx_inc_s = idx_r + 2'd1;
  assign out_hs_s  = m_valid_r & m_ready;
  assign last_hs   = out_hs_s & m_last_r;

  // A result register only moves when its own valid is seen; a missing
  // valid leaves the previous transaction's value in place.
  always_comb begin
    for (int i = 0; i < NUM_RESULTS; i++) begin
      res_next_s[i] = res_r[i];
      if (capture_en && res_vld[i]) begin
        res_next_s[i] = res_in_s[i];
      end else begin
        res_next_s[i] = res_r[i];
      end
    end
  end

  // Word that follows the current one once it is accepted.
  always_comb begin
    next_word_s = res_r[0];
    case (idx_r)
      2'd0:    next_word_s = res_r[1];
      2'd1:    next_word_s = res_r[2];
      default: next_word_s = res_r[0];
    endcase
  end

  // Result storage.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < NUM_RESULTS; i++) begin
        res_r[i] <= '0;
      end
    end else begin
      res_r <= res_next_s;
    end
  end

  // Output stream registers. The first word is taken from res_next_s so a
  // valid arriving together with done is already visible on the first beat.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
      m_data_r  <= '0;
      idx_r     <= 2'd0;
    end else if (drain_start) begin
      m_valid_r <= 1'b1;
      m_last_r  <= 1'b0;
      m_data_r  <= res_next_s[0];
      idx_r     <= 2'd0;
    end else if (out_hs_s) begin
      if (idx_r == 2'd2) begin
        m_valid_r <= 1'b0;
        m_last_r  <= 1'b0;
        idx_r     <= 2'd0;
      end else begin
        m_data_r  <= next_word_s;
        m_last_r  <= (idx_inc_s == 2'd2);
        idx_r     <= idx_inc_s;
      end
    end
  end

  assign m_data  = m_data_r;
  assign m_valid = m_valid_r;
  assign m_last  = m_last_r;

endmodule

// File: rtl/motion_macc_feeder.sv
// -----------------------------------------------------------------------------
// motion_macc_feeder
// Sequencing wrapper around the motion MACC HLS core. Collects ten operand
// words from s_*, holds them on hls_in1..hls_in10, pulses hls_start once,
// waits for hls_done (bounded by TIMEOUT_CYCLES) and plays the three results
// out on m_* with m_last on the third word.
//
// Ports:
//   ap_clk, ap_rst            clock, synchronous active-high reset
//   s_data/s_valid/s_ready    operand stream (first word -> hls_in1)
//   m_data/m_valid/m_ready/m_last  result stream (out1, out2, out3)
//   hls_start, hls_done       core ap_start / ap_done
//   hls_in1..hls_in10         operands to the core
//   hls_out1..3, *_vld        results from the core
//   busy                      low only in LOAD
//   err_timeout               sticky core-timeout flag, cleared by reset
// -----------------------------------------------------------------------------
module motion_macc_feeder
  import motion_macc_feeder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              hls_start,
  input  logic              hls_done,
  output logic [WORD_W-1:0] hls_in1,
  output logic [WORD_W-1:0] hls_in2,
  output logic [WORD_W-1:0] hls_in3,
  output logic [WORD_W-1:0] hls_in4,
  output logic [WORD_W-1:0] hls_in5,
  output logic [WORD_W-1:0] hls_in6,
  output logic [WORD_W-1:0] hls_in7,
  output logic [WORD_W-1:0] hls_in8,
  output logic [WORD_W-1:0] hls_in9,
  output logic [WORD_W-1:0] hls_in10,
  input  logic [WORD_W-1:0] hls_out1,
  input  logic [WORD_W-1:0] hls_out2,
  input  logic [WORD_W-1:0] hls_out3,
  input  logic              hls_out1_vld,
  input  logic              hls_out2_vld,
  input  logic              hls_out3_vld,
  output logic              busy,
  output logic              err_timeout
);

  localparam logic [3:0]            LAST_OP   = 4'(NUM_OPERANDS - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

  feeder_state_e         state_r;
  feeder_state_e         state_next_s;
  word_t                 op_r [NUM_OPERANDS];
  logic [3:0]            op_idx_r;
  logic [WAIT_CNT_W-1:0] wait_cnt_r;
  logic                  s_ready_r;
  logic                  hls_start_r;
  logic                  busy_r;
  logic                  err_timeout_r;
  logic                  ld_hs_s;
  logic                  capture_en_s;
  logic                  drain_go_s;
  logic                  timeout_hit_s;
  logic                  last_hs_s;

  // s_ready_r is a registered decode of LOAD, so it gates the handshake.
  assign ld_hs_s      = s_valid & s_ready_r;
  assign capture_en_s = (state_r == ST_WAIT);

  // Next-state logic. Done is tested before the timeout so it wins a tie.
  always_comb begin
    state_next_s  = state_r;
    drain_go_s    = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_LOAD: begin
        if (ld_hs_s && (op_idx_r == LAST_OP)) begin
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_START: begin
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (hls_done) begin
          state_next_s = ST_DRAIN;
          drain_go_s   = 1'b1;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_next_s  = ST_LOAD;
          timeout_hit_s = 1'b1;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (last_hs_s) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: begin
        state_next_s = ST_LOAD;
      end
    endcase
  end

  // State register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Control outputs registered from the next state so they line up with it.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s_ready_r     <= 1'b0;
      hls_start_r   <= 1'b0;
      busy_r        <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      s_ready_r   <= (state_next_s == ST_LOAD);
      hls_start_r <= (state_next_s == ST_START);
      busy_r      <= (state_next_s != ST_LOAD);
      if (timeout_hit_s) begin
        err_timeout_r <= 1'b1;
      end
    end
  end

  // Operand capture; the registers only change on LOAD handshakes.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      op_idx_r <= 4'd0;
      for (int i = 0; i < NUM_OPERANDS; i++) begin
        op_r[i] <= '0;
      end
    end else if (ld_hs_s) begin
      for (int i = 0; i < NUM_OPERANDS; i++) begin
        if (op_idx_r == 4'(i)) begin
          op_r[i] <= s_data;
        end
      end
      if (op_idx_r == LAST_OP) begin
        op_idx_r <= 4'd0;
      end else begin
        op_idx_r <= op_idx_r + 4'd1;
      end
    end
  end

  // WAIT cycle counter: cleared in START, one count per WAIT cycle.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wait_cnt_r <= '0;
    end else if (state_r == ST_START) begin
      wait_cnt_r <= '0;
    end else if (state_r == ST_WAIT) begin
      wait_cnt_r <= wait_cnt_r + WAIT_CNT_W'(1);
    end
  end

  motion_result_serializer u_serializer (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .capture_en  (capture_en_s),
    .res_vld     ({hls_out3_vld, hls_out2_vld, hls_out1_vld}),
    .res_in1     (hls_out1),
    .res_in2     (hls_out2),
    .res_in3     (hls_out3),
    .drain_start (drain_go_s),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .last_hs     (last_hs_s)
  );

  assign s_ready     = s_ready_r;
  assign hls_start   = hls_start_r;
  assign busy        = busy_r;
  assign err_timeout = err_timeout_r;

  assign hls_in1  = op_r[0];
  assign hls_in2  = op_r[1];
  assign hls_in3  = op_r[2];
  assign hls_in4  = op_r[3];
  assign hls_in5  = op_r[4];
  assign hls_in6  = op_r[5];
  assign hls_in7  = op_r[6];
  assign hls_in8  = op_r[7];
  assign hls_in9  = op_r[8];
  assign hls_in10 = op_r[9];

endmodule
